// File: rtl/ddr4_arb_pkg.sv
// Shared types and default parameters for the two-port DDR4 request arbiter.
package ddr4_arb_pkg;

    localparam int ARB_AW_DEF      = 31;
    localparam int ARB_DW_DEF      = 4;
    localparam int ARB_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_CMPL  = 2'd3
    } arb_state_e;

    function automatic logic [1:0] port_onehot(input logic idx);
        port_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ddr4_rr_pick.sv
// Two-way round-robin pick: the port that was not served last wins a tie.
module ddr4_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       valid_o
);

    // Winner select from the request pair and the last-served port.
    always_comb begin
        valid_o = |req_i;
        win_o   = 1'b0;
        case (req_i)
            2'b01:   win_o = 1'b0;
            2'b10:   win_o = 1'b1;
            2'b11:   win_o = ~last_i;
            default: win_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ddr4_port_arb.sv
// Two-port arbiter in front of ddr4_cont: one outstanding transaction at a time.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module ddr4_port_arb
    import ddr4_arb_pkg::*;
#(
    parameter int AW      = ARB_AW_DEF,
    parameter int DW      = ARB_DW_DEF,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic            clkin,
    input  logic            crst,
    input  logic [1:0]      req,
    input  logic [1:0]      req_wr,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdat,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic [DW-1:0]   rdat,
    output logic [1:0]      err,
    output logic            crd,
    output logic            cwr,
    output logic [AW-1:0]   ca,
    output logic [DW-1:0]   cwdat,
    input  logic [DW-1:0]   crdat,
    input  logic            cbusy
);

    arb_state_e    state_q, state_d;
    logic          win_q, win_d;
    logic          wr_q, wr_d;
    logic          last_q, last_d;
    logic [AW-1:0] ca_q, ca_d;
    logic [DW-1:0] cwdat_q, cwdat_d;
    logic [DW-1:0] rdat_q, rdat_d;
    logic          crd_q, crd_d;
    logic          cwr_q, cwr_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          pick_win_s;
    logic          pick_valid_s;
    logic          tmo_s;

    ddr4_rr_pick u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .win_o   (pick_win_s),
        .valid_o (pick_valid_s)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    // Watchdog register.
    always_ff @(posedge clkin) begin
        if (crst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // Counts every cycle spent in ISSUE or BUSY; cleared while idle.
    always_comb begin
        wd_d  = wd_q;
        tmo_s = 1'b0;
        if (state_q == ST_IDLE) begin
            wd_d = '0;
        end else if ((state_q == ST_ISSUE) || (state_q == ST_BUSY)) begin
            wd_d  = wd_q + WD_W'(1);
            tmo_s = (wd_q == WD_W'(TIMEOUT - 1));
        end else begin
            wd_d = wd_q;
        end
    end
`else
    logic unused_timeout_s;
    assign tmo_s            = 1'b0;
    assign unused_timeout_s = (TIMEOUT > 0);
`endif

    // State and datapath registers.
    always_ff @(posedge clkin) begin
        if (crst) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            wr_q    <= 1'b0;
            last_q  <= 1'b1;
            ca_q    <= '0;
            cwdat_q <= '0;
            rdat_q  <= '0;
            crd_q   <= 1'b0;
            cwr_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
            ca_q    <= ca_d;
            cwdat_q <= cwdat_d;
            rdat_q  <= rdat_d;
            crd_q   <= crd_d;
            cwr_q   <= cwr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; strobes and pulses are computed one edge ahead so outputs stay registered.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        wr_d    = wr_q;
        last_d  = last_q;
        ca_d    = ca_q;
        cwdat_d = cwdat_q;
        rdat_d  = rdat_q;
        crd_d   = crd_q;
        cwr_d   = cwr_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                crd_d = 1'b0;
                cwr_d = 1'b0;
                if (!cbusy && pick_valid_s) begin
                    state_d = ST_ISSUE;
                    win_d   = pick_win_s;
                    wr_d    = req_wr[pick_win_s];
                    ca_d    = pick_win_s ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                    cwdat_d = pick_win_s ? req_wdat[2*DW-1:DW] : req_wdat[DW-1:0];
                    gnt_d   = port_onehot(pick_win_s);
                    crd_d   = ~req_wr[pick_win_s];
                    cwr_d   = req_wr[pick_win_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cbusy) begin
                    state_d = ST_BUSY;
                    crd_d   = 1'b0;
                    cwr_d   = 1'b0;
                end else if (tmo_s) begin
                    state_d = ST_IDLE;
                    crd_d   = 1'b0;
                    cwr_d   = 1'b0;
                    err_d   = port_onehot(win_q);
                    last_d  = win_q;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_BUSY: begin
                if (!cbusy) begin
                    state_d = ST_CMPL;
                    done_d  = port_onehot(win_q);
                    if (!wr_q) begin
                        rdat_d = crdat;
                    end else begin
                        rdat_d = rdat_q;
                    end
                end else if (tmo_s) begin
                    state_d = ST_IDLE;
                    err_d   = port_onehot(win_q);
                    last_d  = win_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_CMPL: begin
                last_d  = win_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                crd_d   = 1'b0;
                cwr_d   = 1'b0;
            end
        endcase
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdat  = rdat_q;
    assign crd   = crd_q;
    assign cwr   = cwr_q;
    assign ca    = ca_q;
    assign cwdat = cwdat_q;

endmodule

// File: tb/tb_ddr4_port_arb.sv
// Self-checking bench for ddr4_port_arb: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations (timeout scenario under ARB_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_ddr4_port_arb;

    localparam int AW  = 31;
    localparam int DW  = 4;
    localparam int TMO = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic            clkin = 1'b0;
    logic            crst;
    logic [1:0]      req, req_wr;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdat;
    logic [1:0]      gnt, done, err;
    logic [DW-1:0]   rdat, cwdat;
    logic            crd, cwr;
    logic [AW-1:0]   ca;
    logic [DW-1:0]   crdat = '0;
    logic            cbusy = 1'b0;

    always #5 clkin = ~clkin;

    ddr4_port_arb #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clkin(clkin), .crst(crst), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdat(req_wdat), .gnt(gnt), .done(done),
        .rdat(rdat), .err(err), .crd(crd), .cwr(cwr), .ca(ca), .cwdat(cwdat),
        .crdat(crdat), .cbusy(cbusy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Controller stand-in: raises cbusy for ctl_lat cycles once a strobe appears.
    bit            ctl_hold  = 1'b1;
    bit            ctl_bval  = 1'b0;
    int            ctl_lat   = 2;
    logic [DW-1:0] ctl_rdata = '0;
    int            bcnt      = 0;
    always @(negedge clkin) begin
        if (ctl_hold) begin
            cbusy = ctl_bval;
            bcnt  = 0;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) cbusy = 1'b0;
        end else if ((crd || cwr) && !cbusy) begin
            cbusy = 1'b1;
            bcnt  = ctl_lat;
            crdat = ctl_rdata;
        end
    end

    // Behavioural model: phase 0 waiting, 1 command offered, 2 controller working, 3 wrap-up.
    int            m_ph = 0, m_own = 0, m_age = 0;
    bit            m_wr = 1'b0, m_last = 1'b1, m_live = 1'b0;
    logic [AW-1:0] m_ca = '0;
    logic [DW-1:0] m_wd = '0, m_rd = '0;
    logic [1:0]    e_gnt = '0, e_done = '0, e_err = '0;
    logic          e_rd = 1'b0, e_wr = 1'b0;
    always @(posedge clkin) begin
        e_gnt  = 2'b00;
        e_done = 2'b00;
        e_err  = 2'b00;
        if (crst) begin
            m_live = 1'b1; m_ph = 0; m_last = 1'b1;
            m_ca = '0; m_wd = '0; m_rd = '0; e_rd = 1'b0; e_wr = 1'b0;
        end else if (m_live) begin
            if (m_ph == 0) begin
                if (!cbusy && req != 2'b00) begin
                    m_own = (req == 2'b11) ? (1 - int'(m_last)) : ((req == 2'b10) ? 1 : 0);
                    m_wr  = req_wr[m_own];
                    m_ca  = req_addr[m_own*AW +: AW];
                    m_wd  = req_wdat[m_own*DW +: DW];
                    e_gnt[m_own] = 1'b1;
                    e_rd  = !m_wr;
                    e_wr  = m_wr;
                    m_ph  = 1;
                    m_age = 0;
                end
            end else if (m_ph == 1 || m_ph == 2) begin
                m_age++;
                if (m_ph == 1 && cbusy) begin
                    m_ph = 2; e_rd = 1'b0; e_wr = 1'b0;
                end else if (m_ph == 2 && !cbusy) begin
                    if (!m_wr) m_rd = crdat;
                    e_done[m_own] = 1'b1;
                    m_ph = 3;
                end else if (TMO_ON && m_age == TMO) begin
                    e_rd = 1'b0; e_wr = 1'b0;
                    e_err[m_own] = 1'b1;
                    m_last = m_own[0];
                    m_ph = 0;
                end
            end else begin
                m_last = m_own[0];
                m_ph = 0;
            end
        end
    end

    bit rec_on = 1'b0;
    int glog[$];

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clkin) begin
        if (m_live) begin
            chk("gnt",   64'(gnt),   64'(e_gnt));
            chk("done",  64'(done),  64'(e_done));
            chk("err",   64'(err),   64'(e_err));
            chk("crd",   64'(crd),   64'(e_rd));
            chk("cwr",   64'(cwr),   64'(e_wr));
            chk("ca",    64'(ca),    64'(m_ca));
            chk("cwdat", 64'(cwdat), 64'(m_wd));
            chk("rdat",  64'(rdat),  64'(m_rd));
            chk("excl",  64'(crd & cwr), 64'h0);
            if (rec_on) begin
                if (gnt[0]) glog.push_back(0);
                if (gnt[1]) glog.push_back(1);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clkin);
            #2;
        end
    endtask

    task automatic wait_pulse(input string nm, input int port, input bit want_done, input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step();
            seen = want_done ? done[port] : gnt[port];
        end
        chk(nm, 64'(seen), 64'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic [AW-1:0] a37;
    int            rep;
    int            crd_n;
    bit            seen_err, seen_done;

    initial begin
        crst = 1'b1; req = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdat = '0;
        a37 = {2'b01, 2'b11, 27'd3193};
        step(2);
        chk("rst_gnt",  64'(gnt),  64'h0);
        chk("rst_crd",  64'(crd),  64'h0);
        chk("rst_ca",   64'(ca),   64'h0);
        chk("rst_rdat", 64'(rdat), 64'h0);
        crst = 1'b0;

        // Both ports requesting continuously: grants must alternate starting with port 0.
        ctl_hold = 1'b0; ctl_lat = 2; ctl_rdata = 4'h7;
        req_addr = {31'd100, 31'd200}; req_wr = 2'b00;
        rec_on = 1'b1; req = 2'b11;
        step(40);
        req = 2'b00;
        step(8);
        rec_on = 1'b0;
        chk("alt_cnt", 64'(glog.size() >= 4), 64'h1);
        for (int i = 0; i < 4; i++) chk("alt_seq", 64'(glog[i]), 64'(i % 2));
        rep = 0;
        for (int i = 1; i < glog.size(); i++) if (glog[i] == glog[i-1]) rep++;
        chk("alt_rep", 64'(rep), 64'h0);

        // Port 0 read, controller busy for 3 cycles, data 4'hA.
        ctl_lat = 3; ctl_rdata = 4'hA;
        req_addr[AW-1:0] = a37; req_wr = 2'b00; req = 2'b01;
        step();
        chk("rd_gnt", 64'(gnt), 64'h1);
        chk("rd_crd", 64'(crd), 64'h1);
        chk("rd_ca",  64'(ca),  64'(a37));
        req = 2'b00;
        wait_pulse("rd_done", 0, 1'b1, 20);
        chk("rd_rdat", 64'(rdat), 64'hA);
        step();

        // Port 1 write of 4'h5 to 3193: rdat must keep 4'hA.
        req_addr[2*AW-1:AW] = 31'd3193; req_wdat[2*DW-1:DW] = 4'h5;
        req_wr = 2'b10; req = 2'b10;
        step();
        chk("wr_gnt",   64'(gnt),   64'h2);
        chk("wr_cwr",   64'(cwr),   64'h1);
        chk("wr_crd",   64'(crd),   64'h0);
        chk("wr_ca",    64'(ca),    64'd3193);
        chk("wr_cwdat", 64'(cwdat), 64'h5);
        req = 2'b00;
        wait_pulse("wr_done", 1, 1'b1, 20);
        chk("wr_rdat", 64'(rdat), 64'hA);
        step();

        // Refresh: cbusy held high blocks arbitration until it falls.
        ctl_hold = 1'b1; ctl_bval = 1'b1; ctl_rdata = 4'h6;
        step();
        req_wr = 2'b00; req = 2'b10;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rf_nogrant", 64'(gnt), 64'h0);
        end
        ctl_bval = 1'b0;
        step();
        chk("rf_gnt", 64'(gnt), 64'h2);
        ctl_hold = 1'b0; req = 2'b00;
        wait_pulse("rf_done", 1, 1'b1, 30);
        chk("rf_rdat", 64'(rdat), 64'h6);
        step();

        // Reset while BUSY abandons the transaction.
        ctl_lat = 6; ctl_rdata = 4'h9; req_wr = 2'b00; req = 2'b01;
        step();
        req = 2'b00;
        step(3);
        crst = 1'b1;
        step();
        chk("mr_gnt",  64'(gnt),  64'h0);
        chk("mr_done", 64'(done), 64'h0);
        chk("mr_err",  64'(err),  64'h0);
        chk("mr_crd",  64'(crd),  64'h0);
        chk("mr_cwr",  64'(cwr),  64'h0);
        chk("mr_ca",   64'(ca),   64'h0);
        chk("mr_cwd",  64'(cwdat), 64'h0);
        chk("mr_rdat", 64'(rdat), 64'h0);
        crst = 1'b0;
        ctl_rdata = 4'h3; req = 2'b10;
        wait_pulse("mr_gnt1", 1, 1'b0, 20);
        req = 2'b00;
        wait_pulse("mr_done1", 1, 1'b1, 30);
        chk("mr_rdat1", 64'(rdat), 64'h3);
        step();

`ifdef ARB_TIMEOUT_EN
        // cbusy stuck low: crd for exactly TIMEOUT cycles, then err instead of done.
        ctl_hold = 1'b1; ctl_bval = 1'b0; req_wr = 2'b00; req = 2'b01;
        wait_pulse("to_gnt", 0, 1'b0, 10);
        req = 2'b00; crd_n = 0; seen_err = 1'b0; seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (crd) crd_n++;
            if (err[0]) seen_err = 1'b1;
            if (done[0]) seen_done = 1'b1;
            step();
        end
        chk("to_crd_len", 64'(crd_n), 64'd16);
        chk("to_err",     64'(seen_err), 64'h1);
        chk("to_nodone",  64'(seen_done), 64'h0);
`else
        crd_n = 0; seen_err = 1'b0; seen_done = 1'b0;
`endif

        step(5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr4_port_arb.md
DDR4_PORT_ARB -- requirements
Module: ddr4_port_arb

Interface
REQ-001 Parameter AW, default 31, controller address width (ca).
REQ-002 Parameter DW, default 4, data width (cwdat/crdat).
REQ-003 Parameter TIMEOUT, default 1024, watchdog limit in clkin cycles (used only with ARB_TIMEOUT_EN).
REQ-004 clkin  in  1  single clock; all logic on rising edge.
REQ-005 crst  in  1  reset; synchronous, active-high.
REQ-006 req  in  2  per-port transaction request; held until gnt.
REQ-007 req_wr  in  2  per-port direction: 1 = write, 0 = read.
REQ-008 req_addr  in  2*AW  port n address at [n*AW +: AW].
REQ-009 req_wdat  in  2*DW  port n write data at [n*DW +: DW].
REQ-010 gnt  out  2  one-cycle accept pulse to the winning port.
REQ-011 done  out  2  one-cycle completion pulse to the owning port.
REQ-012 rdat  out  DW  read data, valid while done is high on a read.
REQ-013 err  out  2  one-cycle timeout pulse; constant 0 without ARB_TIMEOUT_EN.
REQ-014 crd, cwr  out  1 each  read/write strobes to ddr4_cont.
REQ-015 ca  out  AW  address to ddr4_cont.
REQ-016 cwdat  out  DW  write data to ddr4_cont.
REQ-017 crdat  in  DW  read data from ddr4_cont.
REQ-018 cbusy  in  1  controller busy (command accepted, refresh or init in progress).

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, BUSY, CMPL.
REQ-020 IDLE: arbitration only when cbusy=0 and req!=0; otherwise remain IDLE.
REQ-021 Arbitration round-robin: single requester wins; both requesting -> port not granted last wins; after reset port 0 wins.
REQ-022 On the arbitration edge, winner index, req_wr, address and write data SHALL be latched; next state ISSUE.
REQ-023 gnt[w] SHALL be high exactly during the first ISSUE cycle (req sampled high at edge N -> gnt high in cycle N+1).
REQ-024 ISSUE: crd=~wr_l, cwr=wr_l, ca/cwdat from latches; remain until cbusy=1 sampled, then BUSY.
REQ-025 crd and cwr SHALL be 0 in every state except ISSUE; never both 1.
REQ-026 BUSY: remain until cbusy=0 sampled; on that edge capture crdat into rdat if read, then CMPL.
REQ-027 CMPL: done[w]=1 for one cycle, last-granted pointer := w, next IDLE.
REQ-028 Writes SHALL leave rdat unchanged; ca/cwdat hold last values outside ISSUE.
REQ-029 req dropped before its gnt SHALL not be served; req_* may change freely after gnt.
REQ-030 Minimum transaction length 4 cycles; at most one outstanding transaction.

Reset
REQ-031 crst=1 at an edge: state IDLE, crd=cwr=0, ca=0, cwdat=0, rdat=0, gnt=done=err=0, pointer favours port 0, watchdog=0.
REQ-032 Reset mid-transaction SHALL abandon it with no done/err pulse.

Configuration
REQ-033 Macro ARB_TIMEOUT_EN defined: counter runs in ISSUE and BUSY; reaching TIMEOUT cycles -> crd=cwr=0, err[w] pulse instead of done, pointer := w, next IDLE.
REQ-034 ARB_TIMEOUT_EN undefined: no counter; ISSUE/BUSY wait indefinitely; err tied 0.

Structure
REQ-035 Package ddr4_arb_pkg SHALL hold the state enum and AW/DW/TIMEOUT defaults.
REQ-036 Sub-module ddr4_rr_pick SHALL implement the 2-way round-robin pick (req, last pointer -> winner, valid).

Verification
REQ-037 Port 0 read addr {2'b01,2'b11,27'd3193}, cbusy high 3 cycles after crd -> gnt[0] next cycle, crd until cbusy, done[0] with rdat=crdat=4'hA.
REQ-038 Both ports request every cycle, cbusy pulses 2 cycles -> grants alternate 0,1,0,1; no port served twice in a row.
REQ-039 cbusy held high (refresh) while req[1]=1 -> no gnt until cbusy falls; then gnt[1] in the next cycle.
REQ-040 Port 1 write 4'h5 to addr 3193 -> cwr=1, crd=0, ca=3193, cwdat=5; done[1]; rdat unchanged.
REQ-041 crst asserted during BUSY -> all outputs 0 next cycle, no done; next request served normally.
REQ-042 ARB_TIMEOUT_EN, TIMEOUT=16, cbusy stuck 0 -> crd drops after 16 ISSUE cycles, err[0] pulse, no done[0].
